// File: rtl/wordle_guess_entry_pkg.sv
// rtl/wordle_guess_entry_pkg.sv - shared constants and types for the Wordle entry path
package wordle_pkg;

  localparam int         WORD_LEN    = 5;
  localparam int         WORD_W      = 8 * WORD_LEN;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_Z     = 8'h5A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef logic [7:0] letter_t;

  typedef enum logic {
    EDIT = 1'b0,
    SEND = 1'b1
  } entry_state_t;

endpackage

// File: rtl/wordle_guess_entry_if.sv
// rtl/wordle_guess_entry_if.sv - letter stream from guess entry to the game state machine
interface wordle_guess_entry_if;
  import wordle_pkg::*;

  letter_t out_letter;
  logic    out_valid;
  logic    out_last;
  logic    out_ready;

  modport master (output out_letter, output out_valid, output out_last, input out_ready);
  modport slave  (input out_letter, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/wordle_guess_entry_letter_cycler.sv
// rtl/wordle_guess_entry_letter_cycler.sv - selected-letter register, wraps when WORDLE_ENTRY_WRAP_EN is defined
module wordle_letter_cycler
  import wordle_pkg::*;
#(
  parameter letter_t FIRST_CHAR = ASCII_A,
  parameter letter_t LAST_CHAR  = ASCII_Z
) (
  input  logic    Clk,
  input  logic    reset,
  input  logic    up,
  input  logic    down,
  input  logic    load_first,
  output letter_t cur_char
);

  // Value taken when stepping past either end of the alphabet.
`ifdef WORDLE_ENTRY_WRAP_EN
  localparam letter_t PAST_TOP    = FIRST_CHAR;
  localparam letter_t PAST_BOTTOM = LAST_CHAR;
`else
  localparam letter_t PAST_TOP    = LAST_CHAR;
  localparam letter_t PAST_BOTTOM = FIRST_CHAR;
`endif

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cur_char <= FIRST_CHAR;
    end else if (load_first) begin
      cur_char <= FIRST_CHAR;
    end else if (up) begin
      cur_char <= (cur_char == LAST_CHAR) ? PAST_TOP : cur_char + 8'd1;
    end else if (down) begin
      cur_char <= (cur_char == FIRST_CHAR) ? PAST_BOTTOM : cur_char - 8'd1;
    end
  end

endmodule

// File: rtl/wordle_guess_entry.sv
// rtl/wordle_guess_entry.sv - button-driven guess builder and letter streamer (option: WORDLE_ENTRY_WRAP_EN)
module wordle_guess_entry
  import wordle_pkg::*;
#(
  parameter int      WORD_LEN   = wordle_pkg::WORD_LEN,
  parameter letter_t FIRST_CHAR = 8'h41,
  parameter letter_t LAST_CHAR  = 8'h5A,
  parameter letter_t BLANK_CHAR = 8'h20,
  localparam int     CW         = $clog2(WORD_LEN + 1)
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    BtnU,
  input  logic                    BtnD,
  input  logic                    BtnR,
  input  logic                    BtnL,
  input  logic                    BtnC,
  wordle_guess_entry_if.master    out_if,
  output logic                    busy,
  output logic [CW-1:0]           cursor,
  output letter_t                 cur_char,
  output logic [8*WORD_LEN-1:0]   guess_buf,
  output logic                    reject,
  output logic                    sent
);

  localparam logic [CW-1:0] FULL     = CW'(WORD_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_LEN - 1);

  entry_state_t  state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  letter_t       slot_q [WORD_LEN];

  logic    in_edit, act_c, act_l, act_r, act_u, act_d;
  logic    submit, do_reject, erase, commit, xfer, finish;
  logic    valid_d, last_d;
  letter_t letter_d;

  // Button decode: one action per cycle, C > L > R > U > D, nothing outside EDIT.
  always_comb begin
    in_edit   = (state_q == EDIT);
    act_c     = in_edit & BtnC;
    act_l     = in_edit & ~BtnC & BtnL;
    act_r     = in_edit & ~BtnC & ~BtnL & BtnR;
    act_u     = in_edit & ~BtnC & ~BtnL & ~BtnR & BtnU;
    act_d     = in_edit & ~BtnC & ~BtnL & ~BtnR & ~BtnU & BtnD;
    submit    = act_c & (cursor == FULL);
    do_reject = act_c & (cursor != FULL);
    erase     = act_l & (cursor != '0);
    commit    = act_r & (cursor != FULL);
    xfer      = (state_q == SEND) & out_if.out_valid & out_if.out_ready;
    finish    = xfer & (idx_q == LAST_IDX);
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= EDIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      EDIT: if (submit) begin
        state_d = SEND;
        idx_d   = '0;
      end
      SEND: if (finish) begin
        state_d = EDIT;
        idx_d   = '0;
      end else if (xfer) begin
        idx_d = idx_q + CW'(1);
      end
      default: state_d = EDIT;
    endcase
  end

  // Stream outputs are precomputed from the next state so they come straight from flops.
  always_comb begin
    valid_d  = (state_d == SEND);
    last_d   = valid_d & (idx_d == LAST_IDX);
    letter_d = 8'h00;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (valid_d && idx_d == CW'(i)) letter_d = slot_q[i];
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      out_if.out_valid  <= 1'b0;
      out_if.out_last   <= 1'b0;
      out_if.out_letter <= 8'h00;
      busy              <= 1'b0;
      reject            <= 1'b0;
      sent              <= 1'b0;
    end else begin
      out_if.out_valid  <= valid_d;
      out_if.out_last   <= last_d;
      out_if.out_letter <= letter_d;
      busy              <= valid_d;
      reject            <= do_reject;
      sent              <= finish;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cursor <= '0;
      for (int i = 0; i < WORD_LEN; i++) slot_q[i] <= BLANK_CHAR;
    end else begin
      if (finish)      cursor <= '0;
      else if (commit) cursor <= cursor + CW'(1);
      else if (erase)  cursor <= cursor - CW'(1);
      for (int i = 0; i < WORD_LEN; i++) begin
        if (finish)                             slot_q[i] <= BLANK_CHAR;
        else if (commit && cursor == CW'(i))    slot_q[i] <= cur_char;
        else if (erase && cursor == CW'(i + 1)) slot_q[i] <= BLANK_CHAR;
      end
    end
  end

  always_comb begin
    guess_buf = '0;
    for (int i = 0; i < WORD_LEN; i++) guess_buf[8*(WORD_LEN-i)-1 -: 8] = slot_q[i];
  end

  wordle_letter_cycler #(
    .FIRST_CHAR (FIRST_CHAR),
    .LAST_CHAR  (LAST_CHAR)
  ) u_cycler (
    .Clk        (Clk),
    .reset      (reset),
    .up         (act_u),
    .down       (act_d),
    .load_first (commit | finish),
    .cur_char   (cur_char)
  );

endmodule

// File: tb/tb_wordle_guess_entry.sv
// tb/tb_wordle_guess_entry.sv - directed self-checking bench for wordle_guess_entry
module tb_wordle_guess_entry;
  import wordle_pkg::*;

  localparam logic [39:0] BLANK_BUF = {5{8'h20}};

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  btns = 5'b0;   // {C, L, R, U, D}
  logic        busy, reject, sent;
  logic [2:0]  cursor;
  logic [7:0]  cur_char;
  logic [39:0] guess_buf;
  int          n_tests = 0;
  int          n_fail  = 0;

  wordle_guess_entry_if ow();

  wordle_guess_entry dut (
    .Clk       (Clk),
    .reset     (reset),
    .BtnU      (btns[1]),
    .BtnD      (btns[0]),
    .BtnR      (btns[2]),
    .BtnL      (btns[3]),
    .BtnC      (btns[4]),
    .out_if    (ow),
    .busy      (busy),
    .cursor    (cursor),
    .cur_char  (cur_char),
    .guess_buf (guess_buf),
    .reject    (reject),
    .sent      (sent)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic press(input logic [4:0] b);
    btns = b;
    @(negedge Clk);
    btns = 5'b0;
  endtask

  task automatic type_letter(input logic [7:0] ch);
    for (int k = 0; k < int'(ch - 8'h41); k++) press(5'b00010);
    press(5'b00100);
  endtask

  task automatic type_word(input logic [39:0] w);
    for (int k = 4; k >= 0; k--) type_letter(w[8*k +: 8]);
  endtask

  logic [39:0] robot = 40'h52_4F_42_4F_54;
  logic [39:0] hello = 40'h48_45_4C_4C_4F;

  initial begin
    ow.out_ready = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b0;
    check("rst_cursor", cursor, 0);
    check("rst_char", cur_char, 8'h41);
    check("rst_buf", guess_buf, BLANK_BUF);
    check("rst_valid", ow.out_valid, 0);
    check("rst_letter", ow.out_letter, 8'h00);
    check("rst_busy", busy, 0);

    // Full guess streamed with out_ready held high.
    type_word(robot);
    check("robot_buf", guess_buf, robot);
    check("robot_cursor", cursor, 5);
    ow.out_ready = 1'b1;
    press(5'b10000);
    for (int i = 0; i < 5; i++) begin
      check("robot_valid", ow.out_valid, 1);
      check("robot_letter", ow.out_letter, robot[8*(4-i) +: 8]);
      check("robot_last", ow.out_last, (i == 4));
      check("robot_sent_lo", sent, 0);
      @(negedge Clk);
    end
    check("robot_sent", sent, 1);
    check("robot_done_valid", ow.out_valid, 0);
    check("robot_done_busy", busy, 0);
    check("robot_done_cursor", cursor, 0);
    check("robot_done_buf", guess_buf, BLANK_BUF);
    check("robot_done_char", cur_char, 8'h41);
    @(negedge Clk);
    check("robot_sent_pulse", sent, 0);

    // Early submit is refused.
    type_word({8'h41, 8'h42, 8'h43, 8'h20, 8'h20});
    check("part_cursor", cursor, 5);
    repeat (2) press(5'b01000);
    check("part3_cursor", cursor, 3);
    press(5'b10000);
    check("reject_pulse", reject, 1);
    check("reject_cursor", cursor, 3);
    check("reject_busy", busy, 0);
    @(negedge Clk);
    check("reject_clear", reject, 0);
    repeat (3) press(5'b01000);
    check("clear_buf", guess_buf, BLANK_BUF);

    // Backspace.
    type_letter(8'h41);
    type_letter(8'h42);
    press(5'b01000);
    check("bs_cursor", cursor, 1);
    check("bs_top", guess_buf[39:24], 16'h4120);
    check("bs_buf", guess_buf, 40'h41_20_20_20_20);
    press(5'b01000);
    press(5'b01000);
    check("bs_at_zero", cursor, 0);

    // Alphabet ends, then R+U in one cycle commits only.
    press(5'b00001);
`ifdef WORDLE_ENTRY_WRAP_EN
    check("down_at_a", cur_char, 8'h5A);
`else
    check("down_at_a", cur_char, 8'h41);
    repeat (25) press(5'b00010);
`endif
    check("at_z", cur_char, 8'h5A);
    press(5'b00010);
`ifdef WORDLE_ENTRY_WRAP_EN
    check("up_at_z", cur_char, 8'h41);
`else
    check("up_at_z", cur_char, 8'h5A);
`endif
    press(5'b00110);
    check("ru_cursor", cursor, 1);
    check("ru_char", cur_char, 8'h41);
`ifdef WORDLE_ENTRY_WRAP_EN
    check("ru_slot0", guess_buf[39:32], 8'h41);
`else
    check("ru_slot0", guess_buf[39:32], 8'h5A);
`endif
    press(5'b01000);

    // Backpressure on letter 2 with buttons hammered during SEND.
    type_word(hello);
    ow.out_ready = 1'b1;
    press(5'b10000);
    for (int i = 0; i < 5; i++) begin
      check("hello_letter", ow.out_letter, hello[8*(4-i) +: 8]);
      check("hello_last", ow.out_last, (i == 4));
      if (i == 2) begin
        ow.out_ready = 1'b0;
        btns = 5'b11111;
        repeat (3) begin
          @(negedge Clk);
          check("stall_letter", ow.out_letter, 8'h4C);
          check("stall_valid", ow.out_valid, 1);
          check("stall_cursor", cursor, 5);
          check("stall_buf", guess_buf, hello);
        end
        btns = 5'b0;
        ow.out_ready = 1'b1;
      end
      @(negedge Clk);
    end
    check("hello_sent", sent, 1);
    check("hello_cursor", cursor, 0);
    check("hello_buf", guess_buf, BLANK_BUF);

    // Reset in the middle of a SEND.
    type_word(robot);
    press(5'b10000);
    @(negedge Clk);
    @(negedge Clk);
    check("mid_letter2", ow.out_letter, 8'h42);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", ow.out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_buf", guess_buf, BLANK_BUF);
    check("mid_rst_cursor", cursor, 0);
    check("mid_rst_char", cur_char, 8'h41);
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    check("post_rst_valid", ow.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
